// File: rtl/weight_comp_sequencer_if.sv
// ---------------------------------------------------------------------------
// weight_comp_sequencer_if
// Bundles the three buses around the sequencer:
//   upstream entry stream : in_valid / in_ready / in_index / in_value / in_last
//   cell chain            : chain_enable / chain_index / chain_value /
//                           chain_result_in / chain_result_out (MSB = valid)
//   result stream         : res_valid / res_ready / res_data / res_last
//   status                : busy / err_index / err_timeout
// modport slave  : the sequencer's view
// modport master : the surrounding environment's view (source, chain, sink)
// ---------------------------------------------------------------------------
interface weight_comp_sequencer_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int RESULT_WIDTH = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   in_index;
    logic [DATA_WIDTH-1:0]   in_value;
    logic                    in_last;

    logic                    chain_enable;
    logic [DATA_WIDTH-1:0]   chain_index;
    logic [DATA_WIDTH-1:0]   chain_value;
    logic [RESULT_WIDTH:0]   chain_result_in;
    logic [RESULT_WIDTH:0]   chain_result_out;

    logic                    res_valid;
    logic                    res_ready;
    logic [RESULT_WIDTH-1:0] res_data;
    logic                    res_last;

    logic                    busy;
    logic                    err_index;
    logic                    err_timeout;

    modport slave (
        input  in_valid, in_index, in_value, in_last,
        output in_ready,
        output chain_enable, chain_index, chain_value, chain_result_in,
        input  chain_result_out,
        output res_valid, res_data, res_last,
        input  res_ready,
        output busy, err_index, err_timeout
    );

    modport master (
        output in_valid, in_index, in_value, in_last,
        input  in_ready,
        input  chain_enable, chain_index, chain_value, chain_result_in,
        output chain_result_out,
        input  res_valid, res_data, res_last,
        output res_ready,
        input  busy, err_index, err_timeout
    );
endinterface

// File: rtl/weight_comp_sequencer.sv
// ---------------------------------------------------------------------------
// weight_comp_sequencer
// Feeds sparse (index, value) vectors into a chain of weight_comp_cell
// instances, keeping chain_enable high for the whole vector (bubbles become
// null entries), then collects CELL_COUNT tagged results from the end of the
// chain and replays them downstream in arrival order.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : weight_comp_sequencer_if.slave (entry stream, chain, result
//          stream, status flags)
//
// State table:
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | buffer empty, one cycle gap before accepting a new vector
//   S_FEED   | accepting entries; chain gets entry or null every cycle
//   S_DRAIN  | enable low, capturing valid results from the chain tail
//   S_OUTPUT | replaying buffered results on the result stream
// ---------------------------------------------------------------------------
module weight_comp_sequencer #(
    parameter int DATA_WIDTH    = 16,
    parameter int RESULT_WIDTH  = 32,
    parameter int CELL_COUNT    = 4,
    parameter int WEIGHT_AMOUNT = 2,
    parameter int DRAIN_TIMEOUT = 64
) (
    input logic                    clk,
    input logic                    rst,
    weight_comp_sequencer_if.slave bus
);
    localparam int CNT_W = $clog2(CELL_COUNT + 1);
    localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam int IDX_W = (CELL_COUNT > 1) ? $clog2(CELL_COUNT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_OUTPUT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                    chain_en_q;
    logic [DATA_WIDTH-1:0]   chain_idx_q;
    logic [DATA_WIDTH-1:0]   chain_val_q;
    logic                    err_index_q;
    logic                    err_timeout_q;
    logic [CNT_W-1:0]        res_cnt_q;
    logic [CNT_W-1:0]        rd_ptr_q;
    logic [TMO_W-1:0]        tmo_cnt_q;
    logic [RESULT_WIDTH-1:0] buf_q [CELL_COUNT];

    logic             in_fire;
    logic             idx_bad;
    logic             capture;
    logic [CNT_W-1:0] res_cnt_inc;
    logic             cnt_full;
    logic             tmo_hit;
    logic             pop;
    logic             at_last;
    logic             in_ready_c;
    logic             res_valid_c;

    assign idx_bad     = bus.in_index >= DATA_WIDTH'(WEIGHT_AMOUNT);
    assign in_fire     = (state_q == S_FEED) && bus.in_valid;
    assign capture     = (state_q == S_DRAIN) && bus.chain_result_out[RESULT_WIDTH];
    assign res_cnt_inc = res_cnt_q + CNT_W'(capture);
    assign cnt_full    = res_cnt_inc == CNT_W'(CELL_COUNT);
    assign tmo_hit     = tmo_cnt_q == TMO_W'(DRAIN_TIMEOUT - 1);
    assign at_last     = rd_ptr_q == (res_cnt_q - CNT_W'(1));
    assign pop         = (state_q == S_OUTPUT) && bus.res_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        res_valid_c = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_FEED;
            end
            S_FEED: begin
                in_ready_c = 1'b1;
                if (in_fire && bus.in_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // A capture that fills the buffer wins over a simultaneous timeout.
                if (cnt_full) begin
                    state_d = S_OUTPUT;
                end else if (tmo_hit) begin
                    state_d = (res_cnt_inc != '0) ? S_OUTPUT : S_IDLE;
                end
            end
            S_OUTPUT: begin
                res_valid_c = 1'b1;
                if (pop && at_last) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_en_q    <= 1'b0;
            chain_idx_q   <= '0;
            chain_val_q   <= '0;
            err_index_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            res_cnt_q     <= '0;
            rd_ptr_q      <= '0;
            tmo_cnt_q     <= '0;
            for (int i = 0; i < CELL_COUNT; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            // Every FEED cycle presents something: the accepted entry, or a
            // null (0,0) for bubbles and out-of-range indices.
            chain_en_q  <= (state_q == S_FEED);
            chain_idx_q <= (in_fire && !idx_bad) ? bus.in_index : '0;
            chain_val_q <= (in_fire && !idx_bad) ? bus.in_value : '0;

            if (in_fire && idx_bad) begin
                err_index_q <= 1'b1;
            end

            if (state_q == S_DRAIN) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end else begin
                tmo_cnt_q <= '0;
            end

            if (capture) begin
                buf_q[res_cnt_q[IDX_W-1:0]] <= bus.chain_result_out[RESULT_WIDTH-1:0];
                res_cnt_q                   <= res_cnt_inc;
            end

            if ((state_q == S_DRAIN) && !cnt_full && tmo_hit) begin
                err_timeout_q <= 1'b1;
            end

            if (pop) begin
                rd_ptr_q <= rd_ptr_q + CNT_W'(1);
            end

            // Returning to IDLE always leaves the buffer empty.
            if (state_d == S_IDLE) begin
                res_cnt_q <= '0;
                rd_ptr_q  <= '0;
            end
        end
    end

    assign bus.in_ready        = in_ready_c;
    assign bus.chain_enable    = chain_en_q;
    assign bus.chain_index     = chain_idx_q;
    assign bus.chain_value     = chain_val_q;
    assign bus.chain_result_in = '0;
    assign bus.res_valid       = res_valid_c;
    assign bus.res_data        = res_valid_c ? buf_q[rd_ptr_q[IDX_W-1:0]] : '0;
    assign bus.res_last        = res_valid_c && at_last;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.err_index       = err_index_q;
    assign bus.err_timeout     = err_timeout_q;

endmodule

// File: doc/weight_comp_sequencer.md
# weight_comp_sequencer

Sequencer that feeds sparse (index, value) vectors into a chain of CELL_COUNT weight_comp_cell instances and collects their accumulated results. It accepts entries from an upstream valid/ready stream and keeps the chain's enable continuously high for the whole vector by substituting null entries for upstream bubbles. On the vector's last entry it deasserts enable to make the cells drain. It then captures the CELL_COUNT tagged results into an internal buffer and replays them downstream over a valid/ready stream.

## Interface
- DATA_WIDTH, 16, width of index and value
- RESULT_WIDTH, 32, width of result payload; chain result buses carry an extra valid bit at MSB
- CELL_COUNT, 4, number of cells in the chain = results per vector
- WEIGHT_AMOUNT, 2, weights per cell; legal index range 0..WEIGHT_AMOUNT-1
- DRAIN_TIMEOUT, 64, max DRAIN cycles before abort

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream entry valid
- in_ready  out  1  sequencer accepts entry
- in_index  in  DATA_WIDTH  weight index
- in_value  in  DATA_WIDTH  operand value
- in_last  in  1  entry is last of vector
- chain_enable  out  1  to first cell input_enable
- chain_index  out  DATA_WIDTH  to first cell input_index
- chain_value  out  DATA_WIDTH  to first cell input_value
- chain_result_in  out  RESULT_WIDTH+1  to first cell input_result; constant 0 (invalid)
- chain_result_out  in  RESULT_WIDTH+1  from last cell output_result; MSB = valid
- res_valid  out  1  result available downstream
- res_ready  in  1  downstream accepts result
- res_data  out  RESULT_WIDTH  result payload
- res_last  out  1  final result of vector
- busy  out  1  high in any state but IDLE
- err_index  out  1  sticky: out-of-range index seen
- err_timeout  out  1  sticky: drain timed out

## Operation
- States: IDLE, FEED, DRAIN, OUTPUT.
- IDLE → FEED one cycle after the buffer is empty. The buffer is always empty in IDLE.
- FEED:
  - in_ready=1.
  - On handshake, register index/value and drive chain_enable=1 next cycle.
  - Cycle with no handshake: drive a null entry (enable=1, index=0, value=0). It contributes 0 to any accumulation.
  - Entry with in_index ≥ WEIGHT_AMOUNT: accepted but replaced by a null entry; err_index set. Its in_last is still honoured.
  - Handshake with in_last=1 → DRAIN. chain_enable goes 0 in the cycle after the last entry is presented.
- DRAIN:
  - in_ready=0, chain_enable=0.
  - Every cycle with chain_result_out MSB=1, push the low RESULT_WIDTH bits into the buffer (depth CELL_COUNT) and increment the result count.
  - Count reaches CELL_COUNT → OUTPUT.
  - DRAIN_TIMEOUT cycles elapse first → set err_timeout. Go to OUTPUT if count>0, else IDLE.
  - Valid chain outputs outside DRAIN are ignored.
- OUTPUT:
  - Buffer is presented FIFO-order on res_data with res_valid=1.
  - Pop on res_valid&res_ready.
  - res_last=1 only on the final buffered entry.
  - Pop of the final entry → IDLE.
  - res_data and res_valid hold steady while res_ready=0.
- Arithmetic: index/value pass through unmodified. Counters are sized clog2(CELL_COUNT+1) and clog2(DRAIN_TIMEOUT+1) and do not wrap.

## Timing
- Reset values:
  - chain_enable, chain_index, chain_value, chain_result_in = 0
  - in_ready, res_valid, res_last, busy, err_index, err_timeout = 0
  - res_data = 0
  - state = IDLE; counters and buffer cleared
- First in_ready=1: 2nd cycle after rst deasserts (IDLE then FEED).
- Latency: input handshake at edge t → chain_* outputs valid from t+1. chain_* outputs are registered.
- DRAIN timeout counter starts at 0 on the first DRAIN cycle.
- A result captured in the last DRAIN cycle gives res_valid=1 on the next cycle.
- Result popped at edge t → next entry on res_data at t+1. No gap cycles.
- rst mid-operation: next cycle all outputs return to reset values. Buffered results and sticky errors are discarded. An in-flight vector is lost; upstream must resend.
- in_valid high while not in FEED: ignored, in_ready=0.

## Test plan
- Reset: hold rst 3 cycles during FEED with in_valid=1 → all outputs 0 next cycle; in_ready=1 two cycles after release.
- Basic vector, CELL_COUNT=4: entries (1,2),(0,3),(1,4,last) back-to-back → chain sees enable=1 for 3 cycles with those pairs, then 0. Drive 4 valid results 8,6,55,45 on chain_result_out → res_data 8,6,55,45, res_last only on 45.
- Bubble insertion: in_valid low 2 cycles between (1,2) and (0,3,last) → chain sees (1,2),(0,0),(0,0),(0,3), enable never drops before last.
- Bad index: entry (5,7) with WEIGHT_AMOUNT=2 → chain sees (0,0), err_index=1 and stays 1 until rst.
- Timeout: only 2 valid results in DRAIN with DRAIN_TIMEOUT=64 → err_timeout=1 at cycle 64, 2 results output, res_last on 2nd. Zero results → direct to IDLE.
- Backpressure: res_ready low 5 cycles mid-OUTPUT → res_data/res_valid stable. in_ready stays 0 until the last pop, then becomes 1 after IDLE.
